// File: rtl/td4_prog_ctrl.sv
// rtl/td4_prog_ctrl.sv - TD4 program load/read/run/step controller with breakpoint halt.
// Pins are synchronised, then registered once more so mode and strobe effects align in time.
module td4_prog_ctrl #(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4,
  parameter int IMM_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode_i,
  input  logic                    strobe_i,
  input  logic                    addr_load_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic [OP_W-1:0]         op_i,
  input  logic [IMM_W-1:0]        imm_i,
  input  logic [ADDR_W-1:0]       pc_i,
  input  logic                    bp_en_i,
  input  logic [ADDR_W-1:0]       bp_addr_i,
  input  logic [OP_W-1:0]         mem_rop_i,
  input  logic [IMM_W-1:0]        mem_rimm_i,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic                    mem_we_o,
  output logic [OP_W-1:0]         mem_wop_o,
  output logic [IMM_W-1:0]        mem_wimm_o,
  output logic                    cpu_en_o,
  output logic                    cpu_clr_o,
  output logic [OP_W+IMM_W-1:0]   rd_data_o,
  output logic [ADDR_W-1:0]       ptr_o,
  output logic                    halted_o
);

  localparam logic [2:0] ST_LOAD = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_STEP = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;

  logic [1:0]            mode_s1_q, mode_s2_q, mode_q, mode_prev_q;
  logic                  stb_s1_q, stb_s2_q, stb_s3_q, stb_pulse_q;
  logic [2:0]            state_q, state_d, mode_state;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [OP_W+IMM_W-1:0] rd_q, rd_d;
  logic                  clr_q, clr_d;
  logic                  mode_chg, strobe_act, bp_hit, access_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q   <= 2'b00;
      mode_s2_q   <= 2'b00;
      mode_q      <= 2'b00;
      mode_prev_q <= 2'b00;
      stb_s1_q    <= 1'b0;
      stb_s2_q    <= 1'b0;
      stb_s3_q    <= 1'b0;
      stb_pulse_q <= 1'b0;
      state_q     <= ST_LOAD;
      ptr_q       <= '0;
      rd_q        <= '0;
      clr_q       <= 1'b0;
    end else begin
      mode_s1_q   <= mode_i;
      mode_s2_q   <= mode_s1_q;
      mode_q      <= mode_s2_q;
      mode_prev_q <= mode_q;
      stb_s1_q    <= strobe_i;
      stb_s2_q    <= stb_s1_q;
      stb_s3_q    <= stb_s2_q;
      stb_pulse_q <= stb_s2_q & ~stb_s3_q;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rd_q        <= rd_d;
      clr_q       <= clr_d;
    end
  end

  // Transitions fire on a change of the synced mode so HALT can persist under a steady RUN pin.
  assign mode_chg   = (mode_q != mode_prev_q);
  assign strobe_act = stb_pulse_q & ~mode_chg;
  assign bp_hit     = bp_en_i && (pc_i == bp_addr_i);
  assign access_st  = (state_q == ST_LOAD) || (state_q == ST_READ);

  always_comb begin
    mode_state = ST_RUN;
    case (mode_q)
      2'b00:   mode_state = ST_RUN;
      2'b01:   mode_state = ST_STEP;
      2'b10:   mode_state = ST_LOAD;
      default: mode_state = ST_READ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rd_d     = rd_q;
    clr_d    = 1'b0;
    mem_we_o = 1'b0;
    cpu_en_o = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (strobe_act) begin
          if (addr_load_i) begin
            ptr_d = addr_i;
          end else begin
            mem_we_o = 1'b1;
            ptr_d    = ptr_q + ADDR_W'(1);
          end
        end
      end
      ST_READ: begin
        if (strobe_act) begin
          if (addr_load_i) begin
            ptr_d = addr_i;
          end else begin
            rd_d  = {mem_rop_i, mem_rimm_i};
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        cpu_en_o = ~clr_q & ~bp_hit;
        if (bp_hit) state_d = ST_HALT;
      end
      ST_STEP: begin
        cpu_en_o = strobe_act & ~clr_q;
      end
      ST_HALT: begin
        // Resume executes the breakpointed instruction; a jump-to-self halts again.
        cpu_en_o = strobe_act;
        if (strobe_act) state_d = ST_RUN;
      end
      default: state_d = ST_LOAD;
    endcase
    if (mode_chg) begin
      state_d = mode_state;
      clr_d   = access_st && ((mode_state == ST_RUN) || (mode_state == ST_STEP));
    end
  end

  assign mem_addr_o = access_st ? ptr_q : pc_i;
  assign mem_wop_o  = op_i;
  assign mem_wimm_o = imm_i;
  assign cpu_clr_o  = clr_q;
  assign rd_data_o  = rd_q;
  assign ptr_o      = ptr_q;
  assign halted_o   = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4_prog_ctrl.sv
// tb/tb_td4_prog_ctrl.sv - scoreboard bench for td4_prog_ctrl.
// Expected writes are queued when strobes are driven and popped as mem_we_o appears.
module tb_td4_prog_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_i;
  logic       strobe_i, addr_load_i, bp_en_i;
  logic [3:0] addr_i, op_i, imm_i, pc_i, bp_addr_i, mem_rop_i, mem_rimm_i;
  logic [3:0] mem_addr_o, mem_wop_o, mem_wimm_o, ptr_o;
  logic       mem_we_o, cpu_en_o, cpu_clr_o, halted_o;
  logic [7:0] rd_data_o;

  logic [7:0]  mem [16];
  logic [11:0] wr_q [$];
  int n_checks = 0, n_errors = 0;
  int en_cnt = 0, clr_cnt = 0, clr_en_cnt = 0, halt_en_cnt = 0;
  int base;

  always #5 clk = ~clk;

  td4_prog_ctrl #(.ADDR_W(4), .OP_W(4), .IMM_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .strobe_i(strobe_i),
    .addr_load_i(addr_load_i), .addr_i(addr_i), .op_i(op_i), .imm_i(imm_i),
    .pc_i(pc_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i),
    .mem_rop_i(mem_rop_i), .mem_rimm_i(mem_rimm_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wop_o(mem_wop_o), .mem_wimm_o(mem_wimm_o),
    .cpu_en_o(cpu_en_o), .cpu_clr_o(cpu_clr_o), .rd_data_o(rd_data_o),
    .ptr_o(ptr_o), .halted_o(halted_o)
  );

  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  always @(posedge clk) if (mem_we_o) mem[mem_addr_o] <= {mem_wop_o, mem_wimm_o};
  assign mem_rop_i  = mem[mem_addr_o][7:4];
  assign mem_rimm_i = mem[mem_addr_o][3:0];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_en_o) en_cnt++;
      if (cpu_clr_o) clr_cnt++;
      if (cpu_clr_o && cpu_en_o) clr_en_cnt++;
      if (cpu_en_o && halted_o) halt_en_cnt++;
      if (mem_we_o) begin
        if (wr_q.size() == 0) begin
          check("we_unexpected", 1, 0);
        end else begin
          logic [11:0] e;
          e = wr_q.pop_front();
          check("we_addr", int'(mem_addr_o), int'(e[11:8]));
          check("we_data", int'({mem_wop_o, mem_wimm_o}), int'(e[7:0]));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_strobe();
    strobe_i = 1'b1;
    tick(3);
    strobe_i = 1'b0;
    tick(4);
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode_i = m;
    tick(6);
  endtask

  task automatic preset(input logic [3:0] a);
    addr_load_i = 1'b1;
    addr_i = a;
    do_strobe();
    addr_load_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode_i = 2'b00; strobe_i = 1'b0; addr_load_i = 1'b0;
    addr_i = 4'h0; op_i = 4'h0; imm_i = 4'h0; pc_i = 4'h0;
    bp_en_i = 1'b0; bp_addr_i = 4'h0;
    tick(2);
    check("rst_cpu_en", cpu_en_o, 0);
    check("rst_cpu_clr", cpu_clr_o, 0);
    check("rst_we", mem_we_o, 0);
    check("rst_halted", halted_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_ptr", ptr_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    rst_n = 1'b1;
    tick(3);

    // LOAD write and pointer wrap
    set_mode(2'b10);
    preset(4'hE);
    check("load_preset_ptr", ptr_o, 4'hE);
    op_i = 4'h3; imm_i = 4'h5; wr_q.push_back({4'hE, 4'h3, 4'h5});
    do_strobe();
    check("load_ptr_1", ptr_o, 4'hF);
    op_i = 4'h7; imm_i = 4'h9; wr_q.push_back({4'hF, 4'h7, 4'h9});
    do_strobe();
    check("load_ptr_wrap", ptr_o, 4'h0);
    check("load_wr_drained", wr_q.size(), 0);

    // READ readback
    set_mode(2'b11);
    check("read_no_clr", clr_cnt, 0);
    preset(4'hE);
    do_strobe();
    check("read_data_1", rd_data_o, 8'h35);
    check("read_ptr_1", ptr_o, 4'hF);
    do_strobe();
    check("read_data_2", rd_data_o, 8'h79);
    check("read_ptr_2", ptr_o, 4'h0);

    // READ -> RUN clear, then breakpoint halt and resume
    set_mode(2'b00);
    check("run_clr_once", clr_cnt, 1);
    check("run_clr_no_en", clr_en_cnt, 0);
    check("run_en", cpu_en_o, 1);
    bp_addr_i = 4'h3; bp_en_i = 1'b1;
    for (int p = 0; p < 4; p++) begin
      pc_i = 4'(p);
      @(negedge clk);
      check($sformatf("bp_en_pc%0d", p), cpu_en_o, (p != 3) ? 1 : 0);
      check($sformatf("bp_mem_addr_pc%0d", p), mem_addr_o, p);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_halted", halted_o, 1);
    check("bp_halt_en", cpu_en_o, 0);
    tick(3);
    check("halt_held", halted_o, 1);
    bp_en_i = 1'b0;
    do_strobe();
    check("resume_one_en", halt_en_cnt, 1);
    check("resume_run", halted_o, 0);
    check("resume_en", cpu_en_o, 1);

    // STEP: one enable per strobe, breakpoint ignored
    set_mode(2'b01);
    check("step_no_clr", clr_cnt, 1);
    pc_i = 4'h5; bp_addr_i = 4'h5; bp_en_i = 1'b1;
    tick(2);
    en_cnt = 0;
    for (int s = 0; s < 3; s++) begin
      base = en_cnt;
      do_strobe();
      check($sformatf("step_en_%0d", s), en_cnt - base, 1);
    end
    check("step_total", en_cnt, 3);
    check("step_not_halted", halted_o, 0);
    bp_en_i = 1'b0;

    // Strobe and LOAD->READ change in the same cycle
    set_mode(2'b10);
    preset(4'h5);
    check("sim_preset", ptr_o, 4'h5);
    mode_i = 2'b11; strobe_i = 1'b1;
    tick(3);
    strobe_i = 1'b0;
    tick(5);
    check("sim_ptr_held", ptr_o, 4'h5);
    check("sim_rd_held", rd_data_o, 8'h79);

    // Asynchronous reset mid-RUN
    set_mode(2'b00);
    pc_i = 4'h7;
    check("prereset_en", cpu_en_o, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_cpu_en", cpu_en_o, 0);
    check("arst_mem_addr", mem_addr_o, 0);
    check("arst_ptr", ptr_o, 0);
    check("arst_halted", halted_o, 0);
    check("arst_rd_data", rd_data_o, 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check("post_reset_load", mem_addr_o, 0);
    check("wr_q_empty", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/td4_prog_ctrl.md
# td4_prog_ctrl

Parametrised program-load and execution controller for the TD4 core. Sits between the chip pins, the program memory and the CPU. Provides:
- synchronised mode selection (LOAD / READ / RUN / STEP) with debounced-edge strobe handling
- an auto-incrementing load/read pointer
- a single-step mode and a hardware PC breakpoint that halts the core

## Interface

Parameters:
- ADDR_W, 4, program address width; memory depth 2**ADDR_W
- OP_W, 4, opcode field width
- IMM_W, 4, immediate field width

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- mode_i  in  2  asynchronous pin: 00 RUN, 01 STEP, 10 LOAD, 11 READ
- strobe_i  in  1  asynchronous pin; rising edge = one action
- addr_load_i  in  1  with strobe in LOAD/READ: ptr <= addr_i instead of access
- addr_i  in  ADDR_W  pointer preset value
- op_i  in  OP_W  opcode to write
- imm_i  in  IMM_W  immediate to write
- pc_i  in  ADDR_W  CPU program counter
- bp_en_i  in  1  breakpoint enable
- bp_addr_i  in  ADDR_W  breakpoint address
- mem_rop_i  in  OP_W  memory read opcode, combinational from mem_addr_o
- mem_rimm_i  in  IMM_W  memory read immediate
- mem_addr_o  out  ADDR_W  pc_i in RUN/STEP/HALT, ptr in LOAD/READ
- mem_we_o  out  1  write strobe, one cycle
- mem_wop_o  out  OP_W  = op_i
- mem_wimm_o  out  IMM_W  = imm_i
- cpu_en_o  out  1  CPU clock enable; CPU state advances only at edges where high
- cpu_clr_o  out  1  one-cycle CPU synchronous clear
- rd_data_o  out  OP_W+IMM_W  registered {op, imm} from last READ
- ptr_o  out  ADDR_W  current pointer
- halted_o  out  1  high in HALT state

## Operation

- **Synchronisers.** mode_i and strobe_i each pass through a 2-flop synchroniser. stb_pulse = sync strobe high AND previous sync value low. It is one cycle per rising edge.
- **States:** LOAD, READ, RUN, STEP, HALT. Reset state is LOAD.
- **Mode transitions.**
  - Synced mode 10 → LOAD; 11 → READ; 00 → RUN; 01 → STEP.
  - These apply from any state, including HALT. HALT is left only by a mode change or a resume.
  - A transition from LOAD/READ into RUN or STEP pulses cpu_clr_o for exactly one cycle, the first cycle in the new state. cpu_en_o is low in that cycle.
- **LOAD.** On stb_pulse:
  - addr_load_i=1 → ptr <= addr_i; no write.
  - Otherwise → mem_we_o=1 (combinational, that cycle) with mem_addr_o=ptr, then ptr <= ptr+1.
- **READ.** On stb_pulse:
  - addr_load_i=1 → ptr <= addr_i.
  - Otherwise → rd_data_o <= {mem_rop_i, mem_rimm_i}, then ptr <= ptr+1.
- **Pointer.** ptr wraps modulo 2**ADDR_W (all-ones → 0). ptr is held in RUN/STEP/HALT.
- **RUN.**
  - cpu_en_o=1 every cycle except on a breakpoint hit.
  - Hit = bp_en_i AND pc_i==bp_addr_i, evaluated combinationally. On a hit, cpu_en_o=0 that cycle, so the instruction at bp_addr is not executed, and state → HALT at the next edge.
- **STEP.** cpu_en_o = stb_pulse, i.e. exactly one instruction per strobe. Breakpoints are ignored.
- **HALT.**
  - cpu_en_o=0 and halted_o=1.
  - stb_pulse resumes: cpu_en_o=1 for that cycle, executing the breakpointed instruction, and state → RUN.
  - If pc_i still equals bp_addr_i after that (jump-to-self), the core halts again. This is intended.
- **Simultaneous events.** A mode change and stb_pulse in the same cycle: the mode change wins and the strobe is discarded.
- **Writes.** mem_we_o is never high outside LOAD.

## Timing

- **Reset values:**
  - state LOAD, ptr 0, rd_data_o 0
  - all sync flops 0
  - cpu_en_o, cpu_clr_o, mem_we_o, halted_o all 0
  - mem_addr_o = 0
- **Reset mid-operation.** Asynchronous assertion immediately forces the above, aborting any write or step. Deassertion is followed by 2 cycles of sync latency before any new action.
- **Strobe latency.** strobe_i first sampled high at edge k → stb_pulse high in the cycle after edge k+2 → effect (write, ptr update, rd_data_o) committed at edge k+3.
- **Mode latency.** mode_i change sampled at edge k → new state registered at edge k+3.
- **Breakpoint latency.** Zero-cycle suppression of cpu_en_o; halted_o rises 1 cycle after the hit.
- **Throughput.** One LOAD/READ access per stb_pulse; minimum strobe period is 4 cycles (2 high, 2 low) to guarantee edge detection.

## Test plan

- **LOAD write/wrap.** Reset; mode=10; preset ptr=0xE; strobe twice with op/imm=3/5 then 7/9 → mem_we_o pulses at addr 0xE then 0xF; ptr_o = 0x0 after the second strobe (wrap).
- **READ readback.** mode=11; preset ptr=0xE; strobe → rd_data_o=0x35 and ptr_o=0xF; strobe again → rd_data_o=0x79 and ptr_o=0x0.
- **Clear and breakpoint.** LOAD→RUN → cpu_clr_o high exactly one cycle. Set bp_addr_i=3, bp_en_i=1, pc_i counting 0,1,2,3 → cpu_en_o low while pc_i=3; halted_o=1 next cycle. Strobe → cpu_en_o high one cycle; state RUN.
- **STEP.** mode=01; 3 strobes → exactly 3 cpu_en_o pulses; none between strobes; bp at the current pc is ignored.
- **Simultaneous/reset.** Strobe and mode change LOAD→READ arriving in the same cycle → no mem_we_o; ptr unchanged. Assert rst_n low mid-RUN → cpu_en_o=0 and state=LOAD immediately.
